// File: rtl/button_event_pkg.sv
// Shared constants and helpers for the button event reporter.
package button_event_pkg;

    // Nominal debounce window at the host interface clock rate.
    localparam int DEBOUNCE_DEFAULT = 48000;

    // Width of the free-running event counter reported to the host.
    localparam int EVT_COUNT_W = 16;

    // The debounce counter only ever holds 0..cycles-1.
    function automatic int debounce_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One-bit synchroniser and debouncer for an active-low button pin.
// btn_state is the accepted level (1 = pressed). accept is high on the cycle
// whose rising edge will flip btn_state, so the parent can latch edge events
// on that same edge.
module button_debounce
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic ti_clk,
    input  logic reset,
    input  logic button_n,
    output logic btn_state,
    output logic accept
);

    localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          raw_s;
    logic          accept_d;

    // Count consecutive cycles the synchronised level disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    always_comb begin
        raw_s    = ~sync2_q;
        state_d  = state_q;
        cnt_d    = '0;
        accept_d = 1'b0;
        if (raw_s != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d  = raw_s;
                accept_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Sync chain idles at the released pin level so reset never looks like a press.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_state = state_q;
    assign accept    = accept_d;

endmodule

// File: rtl/button_event_reporter.sv
// Debounces the board buttons and reports sticky press/release events,
// a notification trigger and a running event count to the host.
module button_event_reporter
    import button_event_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                   ti_clk,
    input  logic                   reset,
    input  logic [N_BTN-1:0]       button,
    input  logic [N_BTN-1:0]       ack_press,
    input  logic [N_BTN-1:0]       ack_release,
    output logic [N_BTN-1:0]       btn_state,
    output logic [N_BTN-1:0]       evt_press,
    output logic [N_BTN-1:0]       evt_release,
    output logic                   evt_trig,
    output logic [EVT_COUNT_W-1:0] evt_count
);

    logic [N_BTN-1:0]       state_w;
    logic [N_BTN-1:0]       accept_w;
    logic [N_BTN-1:0]       rise;
    logic [N_BTN-1:0]       fall;
    logic [N_BTN-1:0]       evt_press_q;
    logic [N_BTN-1:0]       evt_press_d;
    logic [N_BTN-1:0]       evt_release_q;
    logic [N_BTN-1:0]       evt_release_d;
    logic                   evt_trig_q;
    logic                   evt_trig_d;
    logic [EVT_COUNT_W-1:0] evt_count_q;
    logic [EVT_COUNT_W-1:0] evt_count_d;
    logic [EVT_COUNT_W-1:0] inc;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .ti_clk   (ti_clk),
                .reset    (reset),
                .button_n (button[gi]),
                .btn_state(state_w[gi]),
                .accept   (accept_w[gi])
            );
        end
    endgenerate

    // Classify each accepted flip and compute the next event, trigger and count values.
    always_comb begin
        rise          = accept_w & ~state_w;
        fall          = accept_w & state_w;
        // A new event in the same cycle as its ack keeps the bit set.
        evt_press_d   = (evt_press_q & ~ack_press) | rise;
        evt_release_d = (evt_release_q & ~ack_release) | fall;
        evt_trig_d    = |(rise | fall);
        inc           = '0;
        for (int i = 0; i < N_BTN; i++) begin
            inc = inc + EVT_COUNT_W'(rise[i] | fall[i]);
        end
        evt_count_d   = evt_count_q + inc;
    end

    // Event latches, trigger pulse and wrapping counter.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            evt_press_q   <= '0;
            evt_release_q <= '0;
            evt_trig_q    <= 1'b0;
            evt_count_q   <= '0;
        end else begin
            evt_press_q   <= evt_press_d;
            evt_release_q <= evt_release_d;
            evt_trig_q    <= evt_trig_d;
            evt_count_q   <= evt_count_d;
        end
    end

    assign btn_state   = state_w;
    assign evt_press   = evt_press_q;
    assign evt_release = evt_release_q;
    assign evt_trig    = evt_trig_q;
    assign evt_count   = evt_count_q;

endmodule

// File: tb/tb_button_event_reporter.sv
// Randomised and directed bench for button_event_reporter with a per-cycle
// reference model built from the "last D synchronised samples agree" rule.
module tb_button_event_reporter;

    localparam int N = 4;
    localparam int D = 4;

    logic          ti_clk = 1'b0;
    logic          reset  = 1'b1;
    logic [N-1:0]  button = 4'hF;
    logic [N-1:0]  ack_press = '0;
    logic [N-1:0]  ack_release = '0;
    logic [N-1:0]  btn_state;
    logic [N-1:0]  evt_press;
    logic [N-1:0]  evt_release;
    logic          evt_trig;
    logic [15:0]   evt_count;

    int errors = 0;
    int checks = 0;

    button_event_reporter #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .ti_clk     (ti_clk),
        .reset      (reset),
        .button     (button),
        .ack_press  (ack_press),
        .ack_release(ack_release),
        .btn_state  (btn_state),
        .evt_press  (evt_press),
        .evt_release(evt_release),
        .evt_trig   (evt_trig),
        .evt_count  (evt_count)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pin samples taken at each clock edge, newest first.
    // A bit flips when the D samples that have cleared the 2-flop sync all
    // show the opposite of its current debounced level.
    logic [N-1:0] hist [0:D];
    logic [N-1:0] m_state;
    logic [N-1:0] m_press;
    logic [N-1:0] m_release;
    logic         m_trig;
    logic [15:0]  m_count;

    initial begin
        forever begin
            logic [N-1:0] toggle;
            @(posedge ti_clk);
            if (reset) begin
                for (int j = 0; j <= D; j++) hist[j] = '1;
                m_state   = '0;
                m_press   = '0;
                m_release = '0;
                m_trig    = 1'b0;
                m_count   = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    toggle[i] = 1'b1;
                    // pin level equal to the debounced level means "opposite" (active-low)
                    for (int j = 1; j <= D; j++)
                        if (hist[j][i] != m_state[i]) toggle[i] = 1'b0;
                end
                m_press   = (m_press & ~ack_press) | (toggle & ~m_state);
                m_release = (m_release & ~ack_release) | (toggle & m_state);
                m_trig    = |toggle;
                m_count   = m_count + 16'($countones(toggle));
                m_state   = m_state ^ toggle;
                for (int j = D; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = button;
            end
            @(negedge ti_clk);
            chk("btn_state", 32'(btn_state), 32'(m_state));
            chk("evt_press", 32'(evt_press), 32'(m_press));
            chk("evt_release", 32'(evt_release), 32'(m_release));
            chk("evt_trig", 32'(evt_trig), 32'(m_trig));
            chk("evt_count", 32'(evt_count), 32'(m_count));
        end
    end

    // Advance n rising edges, then settle 2 time units past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge ti_clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] b;

        // Reset held 3 cycles with buttons released
        step(3);
        chk("reset_btn_state", 32'(btn_state), 32'h0);
        chk("reset_evt_press", 32'(evt_press), 32'h0);
        chk("reset_evt_release", 32'(evt_release), 32'h0);
        chk("reset_evt_trig", 32'(evt_trig), 32'h0);
        chk("reset_evt_count", 32'(evt_count), 32'h0);
        reset = 1'b0;
        step(2);

        // Clean press then release on button 0
        button = 4'hE;
        step(5);
        chk("press_latency_early", 32'(btn_state), 32'h0);
        step(1);
        chk("press_btn_state", 32'(btn_state), 32'h1);
        chk("press_evt_press", 32'(evt_press), 32'h1);
        chk("press_evt_trig", 32'(evt_trig), 32'h1);
        chk("press_evt_count", 32'(evt_count), 32'h1);
        step(1);
        chk("press_trig_one_cycle", 32'(evt_trig), 32'h0);
        button = 4'hF;
        step(6);
        chk("release_evt_release", 32'(evt_release), 32'h1);
        chk("release_evt_count", 32'(evt_count), 32'h2);
        ack_press = 4'hF;
        ack_release = 4'hF;
        step(1);
        ack_press = '0;
        ack_release = '0;
        chk("ack_clears_press", 32'(evt_press), 32'h0);
        chk("ack_clears_release", 32'(evt_release), 32'h0);

        // Glitch of D-1 cycles is ignored, D cycles is accepted
        button = 4'hD;
        step(3);
        button = 4'hF;
        step(10);
        chk("glitch_btn_state", 32'(btn_state), 32'h0);
        chk("glitch_evt_count", 32'(evt_count), 32'h2);
        button = 4'hD;
        step(4);
        button = 4'hF;
        step(2);
        chk("hold4_btn_state", 32'(btn_state), 32'h2);
        chk("hold4_evt_count", 32'(evt_count), 32'h3);
        step(6);
        chk("hold4_release_count", 32'(evt_count), 32'h4);

        // Ack arriving in the same cycle as a new press on bit 2
        button = 4'hB;
        step(6);
        chk("race_first_press", 32'(evt_press), 32'h6);
        button = 4'hF;
        step(6);
        button = 4'hB;
        step(5);
        ack_press = 4'h4;
        step(1);
        ack_press = '0;
        chk("race_new_event_wins", 32'(evt_press), 32'h6);
        ack_press = 4'h4;
        step(1);
        ack_press = '0;
        chk("ack_alone_clears_bit2", 32'(evt_press), 32'h2);
        chk("race_evt_count", 32'(evt_count), 32'h7);

        // Simultaneous press on all buttons
        button = 4'hF;
        step(8);
        ack_press = 4'hF;
        ack_release = 4'hF;
        step(1);
        ack_press = '0;
        ack_release = '0;
        button = 4'h0;
        step(6);
        chk("simul_trig", 32'(evt_trig), 32'h1);
        chk("simul_count", 32'(evt_count), 32'd12);
        chk("simul_btn_state", 32'(btn_state), 32'hF);
        step(1);
        chk("simul_single_pulse", 32'(evt_trig), 32'h0);
        button = 4'hF;
        step(8);

        // Randomised pins and acks
        for (int c = 0; c < 1500; c++) begin
            b = button;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            button      = b;
            ack_press   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            ack_release = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            step(1);
        end
        ack_press = '0;
        ack_release = '0;
        button = 4'hF;
        step(10);

        // Counter wrap: restart from zero, then 16383 four-button flips
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int k = 0; k < 16383; k++) begin
            button = ~button;
            step(D);
        end
        step(8);
        chk("wrap_pre_count", 32'(evt_count), 32'hFFFC);
        button = 4'h7;
        step(8);
        chk("wrap_ffff", 32'(evt_count), 32'hFFFF);
        button = 4'hF;
        step(8);
        chk("wrap_zero", 32'(evt_count), 32'h0000);

        // Reset two cycles into a debounce discards the pending edge
        button = 4'h7;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset_count", 32'(evt_count), 32'h0);
        step(5);
        chk("mid_reset_no_early_event", 32'(btn_state), 32'h0);
        step(1);
        chk("mid_reset_full_debounce", 32'(btn_state), 32'h8);
        chk("mid_reset_count_after", 32'(evt_count), 32'h1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
